// File: rtl/dut.sv
// USB full-speed transmit-only PHY with a Wishbone classic register slave.
// Define USB_TX_BITSTUFF_EN to insert a stuff bit after six consecutive ones.
module dut (
  input  logic        clk_clk48,
  input  logic        reset,
  output logic        clk_clk12,
  inout  wire         usb_d_p,
  inout  wire         usb_d_n,
  output logic        usb_pullup,
  output logic        usb_tx_en,
  input  logic [29:0] wishbone_adr,
  input  logic [31:0] wishbone_dat_w,
  output logic [31:0] wishbone_dat_r,
  input  logic [3:0]  wishbone_sel,
  input  logic        wishbone_cyc,
  input  logic        wishbone_stb,
  input  logic        wishbone_we,
  input  logic [2:0]  wishbone_cti,
  input  logic [1:0]  wishbone_bte,
  output logic        wishbone_ack,
  output logic        wishbone_err
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ONES_W  = 3;
  localparam logic [31:0] ID_VALUE = 32'h5553_4231;
  localparam logic [1:0]  LINE_J   = 2'b10;
  localparam logic [1:0]  LINE_K   = 2'b01;
  localparam logic [1:0]  LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_DATA, ST_SE0A, ST_SE0B, ST_EOPJ
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          div_q;
  logic [1:0]          ctrl_q, ctrl_d;
  logic                ovf_q, ovf_d, udr_q, udr_d;
  logic [BYTE_W-1:0]   hold_q, hold_d, sh_q, sh_d, src_c;
  logic                hold_last_q, hold_last_d, hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0]    sh_cnt_q, sh_cnt_d;
  logic                sh_last_q, sh_last_d;
  logic                line_q, line_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic                oe_q, oe_d;
  logic [1:0]          drv_q, drv_d;
  logic [1:0]          sync1_q, sync2_q;
  logic                done_q, ack_q, err_q;
  logic [31:0]         dat_r_q, rdata_c;
  logic                tick_c, req_c, hit_c, wr_c;
  logic                wr_ctrl_c, wr_stat_c, wr_tx_c;
  logic                stuff_c, emit_c, hold_take_c, udr_set_c, tx_busy_c;
  logic                unused_c;

  assign unused_c = ^{wishbone_sel, wishbone_cti, wishbone_bte, wishbone_dat_w[31:9]};

  assign clk_clk12      = div_q[1];
  assign tick_c         = (div_q == 2'd1);
  assign usb_pullup     = ctrl_q[0];
  assign usb_tx_en      = oe_q;
  assign usb_d_p        = oe_q ? drv_q[1] : 1'bz;
  assign usb_d_n        = oe_q ? drv_q[0] : 1'bz;
  assign wishbone_ack   = ack_q;
  assign wishbone_err   = err_q;
  assign wishbone_dat_r = dat_r_q;

  // One response per stb assertion; done_q blocks repeats until stb drops.
  assign req_c     = wishbone_cyc & wishbone_stb & ~done_q;
  assign hit_c     = (wishbone_adr < 30'd4);
  assign wr_c      = req_c & hit_c & wishbone_we;
  assign wr_ctrl_c = wr_c & (wishbone_adr[1:0] == 2'd0);
  assign wr_stat_c = wr_c & (wishbone_adr[1:0] == 2'd1);
  assign wr_tx_c   = wr_c & (wishbone_adr[1:0] == 2'd2);
  assign tx_busy_c = (state_q != ST_IDLE);

  always_comb begin
    rdata_c = '0;
    unique case (wishbone_adr[1:0])
      2'd0:    rdata_c = {30'd0, ctrl_q};
      2'd1:    rdata_c = {26'd0, udr_q, ovf_q, hold_vld_q, tx_busy_c, sync2_q};
      2'd2:    rdata_c = '0;
      default: rdata_c = ID_VALUE;
    endcase
  end

`ifdef USB_TX_BITSTUFF_EN
  assign stuff_c = (state_q == ST_DATA) && (ones_q == ONES_W'(6));
`else
  assign stuff_c = 1'b0;
`endif

  // Next data bit comes from the shift register, or straight from the holding byte.
  assign src_c  = (sh_cnt_q != '0) ? sh_q : hold_q;
  assign emit_c = (sh_cnt_q != '0) | (~sh_last_q & hold_vld_q);

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    sh_d        = sh_q;
    sh_cnt_d    = sh_cnt_q;
    sh_last_d   = sh_last_q;
    ones_d      = ones_q;
    hold_take_c = 1'b0;
    udr_set_c   = 1'b0;
    oe_d        = 1'b0;
    drv_d       = LINE_SE0;
    if (tick_c) begin
      unique case (state_q)
        ST_IDLE: if (hold_vld_q) begin
          state_d     = ST_SYNC;
          line_d      = 1'b1;
          sh_d        = hold_q;
          sh_cnt_d    = CNT_W'(8);
          sh_last_d   = hold_last_q;
          ones_d      = '0;
          hold_take_c = 1'b1;
        end
        ST_SYNC, ST_DATA: begin
          state_d = ST_DATA;
          if (stuff_c) begin
            line_d = ~line_q;
            ones_d = '0;
          end else if (emit_c) begin
            line_d   = src_c[0] ? line_q : ~line_q;
            ones_d   = src_c[0] ? ones_q + ONES_W'(1) : '0;
            sh_d     = {1'b0, src_c[BYTE_W-1:1]};
            sh_cnt_d = ((sh_cnt_q != '0) ? sh_cnt_q : CNT_W'(8)) - CNT_W'(1);
            if (sh_cnt_q == '0) begin
              sh_last_d   = hold_last_q;
              hold_take_c = 1'b1;
            end
          end else begin
            state_d   = ST_SE0A;
            udr_set_c = ~sh_last_q;
          end
        end
        ST_SE0A: state_d = ST_SE0B;
        ST_SE0B: state_d = ST_EOPJ;
        ST_EOPJ: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // force_se0 only takes the lines while no packet is in flight.
    oe_d = (state_d != ST_IDLE) | ctrl_q[1];
    unique case (state_d)
      ST_IDLE, ST_SE0A, ST_SE0B: drv_d = LINE_SE0;
      ST_EOPJ:                   drv_d = LINE_J;
      default:                   drv_d = line_d ? LINE_J : LINE_K;
    endcase
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    ovf_d       = ovf_q;
    udr_d       = udr_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_vld_d  = hold_vld_q;
    if (wr_ctrl_c) ctrl_d = wishbone_dat_w[1:0];
    if (wr_stat_c && wishbone_dat_w[4]) ovf_d = 1'b0;
    if (wr_stat_c && wishbone_dat_w[5]) udr_d = 1'b0;
    if (udr_set_c) udr_d = 1'b1;
    if (hold_take_c) hold_vld_d = 1'b0;
    if (wr_tx_c) begin
      if (hold_vld_q) begin
        ovf_d = 1'b1;
      end else begin
        hold_d      = wishbone_dat_w[7:0];
        hold_last_d = wishbone_dat_w[8];
        hold_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk48 or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      ovf_q       <= 1'b0;
      udr_q       <= 1'b0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_vld_q  <= 1'b0;
      sh_q        <= '0;
      sh_cnt_q    <= '0;
      sh_last_q   <= 1'b0;
      line_q      <= 1'b1;
      ones_q      <= '0;
      oe_q        <= 1'b0;
      drv_q       <= LINE_SE0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_r_q     <= '0;
    end else begin
      div_q       <= div_q + 2'd1;
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      ovf_q       <= ovf_d;
      udr_q       <= udr_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_vld_q  <= hold_vld_d;
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_last_q   <= sh_last_d;
      line_q      <= line_d;
      ones_q      <= ones_d;
      oe_q        <= oe_d;
      drv_q       <= drv_d;
      sync1_q     <= {usb_d_p, usb_d_n};
      sync2_q     <= sync1_q;
      done_q      <= wishbone_cyc & wishbone_stb;
      ack_q       <= req_c & hit_c;
      err_q       <= req_c & ~hit_c;
      dat_r_q     <= (req_c & hit_c & ~wishbone_we) ? rdata_c : '0;
    end
  end

endmodule

// File: tb/tb_dut.sv
// Randomized scoreboard bench for the USB transmit PHY: bus responses and
// line symbols are predicted by a packet-level model and checked by monitors.
module tb_dut;

  localparam logic [1:0]  SYM_J    = 2'b10;
  localparam logic [1:0]  SYM_K    = 2'b01;
  localparam logic [1:0]  SYM_SE0  = 2'b00;
  localparam logic [31:0] ID_VALUE = 32'h5553_4231;

  typedef struct {
    logic        is_err;
    logic [31:0] mask;
    logic [31:0] data;
  } wb_exp_t;

  logic        clk_clk48 = 1'b0;
  logic        reset = 1'b0;
  logic        clk_clk12, usb_pullup, usb_tx_en;
  wire         usb_d_p, usb_d_n;
  logic [29:0] wishbone_adr = '0;
  logic [31:0] wishbone_dat_w = '0;
  logic [31:0] wishbone_dat_r;
  logic [3:0]  wishbone_sel = 4'hF;
  logic        wishbone_cyc = 1'b0, wishbone_stb = 1'b0, wishbone_we = 1'b0;
  logic [2:0]  wishbone_cti = '0;
  logic [1:0]  wishbone_bte = '0;
  logic        wishbone_ack, wishbone_err;

  pullup   (usb_d_p);
  pulldown (usb_d_n);

  int          checks = 0, failures = 0;
  wb_exp_t     exp_wb[$];
  logic [1:0]  exp_sym[$];
  logic [7:0]  pkt[$];
  bit          mon_en = 1'b0;
  int          sym_seen = 0;
  logic        prev_ack = 1'b0;

  dut u_dut (
    .clk_clk48(clk_clk48), .reset(reset), .clk_clk12(clk_clk12),
    .usb_d_p(usb_d_p), .usb_d_n(usb_d_n), .usb_pullup(usb_pullup), .usb_tx_en(usb_tx_en),
    .wishbone_adr(wishbone_adr), .wishbone_dat_w(wishbone_dat_w), .wishbone_dat_r(wishbone_dat_r),
    .wishbone_sel(wishbone_sel), .wishbone_cyc(wishbone_cyc), .wishbone_stb(wishbone_stb),
    .wishbone_we(wishbone_we), .wishbone_cti(wishbone_cti), .wishbone_bte(wishbone_bte),
    .wishbone_ack(wishbone_ack), .wishbone_err(wishbone_err)
  );

  always #10 clk_clk48 = ~clk_clk48;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Bus response monitor: pops the expected response whenever ack or err is seen.
  always @(negedge clk_clk48) begin
    wb_exp_t e;
    if (wishbone_ack) begin
      checks++;
      if (prev_ack) begin
        failures++;
        $display("FAIL wb_ack_width ack high 2 cycles, required 1");
      end
    end
    prev_ack = wishbone_ack;
    if (wishbone_ack || wishbone_err) begin
      checks++;
      if (exp_wb.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected ack=%b err=%b, required no response", wishbone_ack, wishbone_err);
      end else begin
        e = exp_wb.pop_front();
        if (wishbone_err !== e.is_err || wishbone_ack !== !e.is_err) begin
          failures++;
          $display("FAIL wb_kind ack=%b err=%b, required err=%b", wishbone_ack, wishbone_err, e.is_err);
        end
        if (e.mask != 32'd0) begin
          checks++;
          if ((wishbone_dat_r & e.mask) !== e.data) begin
            failures++;
            $display("FAIL wb_data actual=%h expected=%h mask=%h", wishbone_dat_r, e.data, e.mask);
          end
        end
      end
    end
  end

  // Line monitor: samples each bit time near its middle.
  initial begin
    logic [1:0] sym, e;
    forever begin
      @(posedge clk_clk12);
      @(negedge clk_clk48);
      @(negedge clk_clk48);
      if (mon_en && usb_tx_en) begin
        sym = {usb_d_p, usb_d_n};
        sym_seen++;
        checks++;
        if (exp_sym.size() == 0) begin
          failures++;
          $display("FAIL line_extra symbol=%b, required line released", sym);
        end else begin
          e = exp_sym.pop_front();
          if (sym !== e) begin
            failures++;
            $display("FAIL line_symbol actual=%b expected=%b", sym, e);
          end
        end
      end
    end
  end

  task automatic wb_xfer(input logic [29:0] adr, input logic we, input logic [31:0] dat,
                         input logic is_err, input logic [31:0] mask, input logic [31:0] exp,
                         output logic [31:0] rd);
    wb_exp_t e;
    int lat;
    @(negedge clk_clk48);
    e.is_err = is_err; e.mask = mask; e.data = exp;
    exp_wb.push_back(e);
    wishbone_adr = adr; wishbone_we = we; wishbone_dat_w = dat;
    wishbone_cyc = 1'b1; wishbone_stb = 1'b1;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk_clk48);
      if (wishbone_ack || wishbone_err) begin
        lat = n;
        break;
      end
    end
    rd = wishbone_dat_r;
    wishbone_cyc = 1'b0; wishbone_stb = 1'b0; wishbone_we = 1'b0;
    check("wb_latency", 32'(lat), 32'd1);
    if (lat == 0) void'(exp_wb.pop_back());
    @(negedge clk_clk48);
  endtask

  task automatic wb_wr(input logic [29:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    wb_xfer(adr, 1'b1, dat, 1'b0, 32'd0, 32'd0, rd);
  endtask

  task automatic wb_rd(input logic [29:0] adr, input logic [31:0] mask, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(adr, 1'b0, 32'd0, 1'b0, mask, exp, rd);
  endtask

  // Packet-level model: J, NRZI data LSB first (optionally stuffed), SE0, SE0, J.
  task automatic model_packet();
    logic lvl;
    int   ones;
    lvl = 1'b1;
    ones = 0;
    exp_sym.push_back(SYM_J);
    foreach (pkt[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (!pkt[i][b]) lvl = ~lvl;
        exp_sym.push_back(lvl ? SYM_J : SYM_K);
        ones = pkt[i][b] ? ones + 1 : 0;
`ifdef USB_TX_BITSTUFF_EN
        if (ones == 6) begin
          lvl = ~lvl;
          exp_sym.push_back(lvl ? SYM_J : SYM_K);
          ones = 0;
        end
`endif
      end
    end
    exp_sym.push_back(SYM_SE0);
    exp_sym.push_back(SYM_SE0);
    exp_sym.push_back(SYM_J);
  endtask

  task automatic wait_not_full();
    logic [31:0] rd;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      wb_xfer(30'd1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, rd);
      if (rd[3] == 1'b0) ok = 1'b1;
    end
    check("tx_full_clears", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 1500 && !ok; n++) begin
      @(negedge clk_clk48);
      if (!usb_tx_en && exp_sym.size() == 0) ok = 1'b1;
    end
    check("packet_complete", 32'(ok), 32'd1);
    exp_sym.delete();
  endtask

  // Sends pkt[] as one packet; the final byte carries the last flag if asked.
  task automatic send_bytes(input bit last_flag);
    int n;
    n = pkt.size();
    model_packet();
    for (int i = 0; i < n; i++) begin
      if (i > 0) wait_not_full();
      wb_wr(30'd2, {23'd0, (last_flag && i == n - 1), pkt[i]});
    end
    pkt.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic [29:0] badr;
    int nb;

    repeat (3) @(negedge clk_clk48);
    check("rst_tx_en", 32'(usb_tx_en), 32'd0);
    check("rst_pullup", 32'(usb_pullup), 32'd0);
    check("rst_clk12", 32'(clk_clk12), 32'd0);
    check("rst_ack_err", 32'({wishbone_ack, wishbone_err}), 32'd0);
    check("rst_dat_r", wishbone_dat_r, 32'd0);
    check("rst_lines", 32'({usb_d_p, usb_d_n}), 32'(SYM_J));
    reset = 1'b1;
    repeat (4) @(negedge clk_clk48);
    mon_en = 1'b1;

    // Register map and error decode.
    wb_rd(30'd3, 32'hFFFF_FFFF, ID_VALUE);
    wb_xfer(30'd7, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, rd);
    for (int i = 0; i < 3; i++) begin
      badr = 30'($urandom_range(32'h3FFF_FFFF, 4));
      wb_xfer(badr, 1'b1, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 32'd0, rd);
    end
    wb_rd(30'd0, 32'hFFFF_FFFF, 32'd0);
    wb_wr(30'd0, 32'd1);
    check("pullup_on", 32'(usb_pullup), 32'd1);
    wb_rd(30'd0, 32'hFFFF_FFFF, 32'd1);
    wb_rd(30'd1, 32'hFFFF_FFFF, 32'h0000_0002);

    // Single last byte 0x80.
    sym_seen = 0;
    pkt.push_back(8'h80);
    send_bytes(1'b1);
    wait_idle();
    check("pkt80_bit_times", 32'(sym_seen), 32'd12);
    wb_rd(30'd1, 32'h0000_003F, 32'h0000_0002);

    // Two all-ones bytes: stuffing boundary.
    pkt.push_back(8'hFF);
    pkt.push_back(8'hFF);
    send_bytes(1'b1);
    wait_idle();

    // Random multi-byte packets.
    for (int p = 0; p < 5; p++) begin
      nb = int'($urandom_range(3, 1));
      for (int i = 0; i < nb; i++) pkt.push_back(8'($urandom));
      send_bytes(1'b1);
      wait_idle();
    end
    wb_rd(30'd1, 32'h0000_003F, 32'h0000_0002);

    // Overflow: A shifting, B held, C and D dropped.
    pkt.push_back(8'($urandom));
    pkt.push_back(8'($urandom));
    model_packet();
    wb_wr(30'd2, {23'd0, 1'b0, pkt[0]});
    repeat (8) @(negedge clk_clk48);
    wb_wr(30'd2, {23'd0, 1'b1, pkt[1]});
    wb_wr(30'd2, {23'd0, 1'b1, 8'($urandom)});
    wb_wr(30'd2, {23'd0, 1'b1, 8'($urandom)});
    pkt.delete();
    wb_rd(30'd1, 32'h0000_003C, 32'h0000_001C);
    wait_idle();
    wb_rd(30'd1, 32'h0000_003F, 32'h0000_0012);
    wb_wr(30'd1, 32'h0000_0010);
    wb_rd(30'd1, 32'h0000_003F, 32'h0000_0002);

    // Underrun: single byte without the last flag.
    pkt.push_back(8'($urandom));
    send_bytes(1'b0);
    wait_idle();
    wb_rd(30'd1, 32'h0000_003F, 32'h0000_0022);
    wb_wr(30'd1, 32'h0000_0020);
    wb_rd(30'd1, 32'h0000_003F, 32'h0000_0002);

    // force_se0 while idle.
    mon_en = 1'b0;
    wb_wr(30'd0, 32'd3);
    repeat (2) @(negedge clk_clk48);
    check("force_tx_en", 32'(usb_tx_en), 32'd1);
    check("force_lines", 32'({usb_d_p, usb_d_n}), 32'(SYM_SE0));
    wb_rd(30'd1, 32'h0000_003F, 32'h0000_0000);
    wb_wr(30'd0, 32'd1);
    repeat (2) @(negedge clk_clk48);
    check("unforce_tx_en", 32'(usb_tx_en), 32'd0);
    mon_en = 1'b1;

    // force_se0 raised mid-packet must not disturb it.
    pkt.push_back(8'($urandom));
    send_bytes(1'b1);
    repeat (16) @(negedge clk_clk48);
    wb_wr(30'd0, 32'd3);
    begin
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 600 && !ok; n++) begin
        @(negedge clk_clk48);
        if (exp_sym.size() == 0) ok = 1'b1;
      end
      mon_en = 1'b0;
      check("force_pkt_done", 32'(ok), 32'd1);
      exp_sym.delete();
    end
    repeat (8) @(negedge clk_clk48);
    check("force_after_pkt_tx_en", 32'(usb_tx_en), 32'd1);
    check("force_after_pkt_lines", 32'({usb_d_p, usb_d_n}), 32'(SYM_SE0));
    wb_wr(30'd0, 32'd1);
    repeat (3) @(negedge clk_clk48);
    check("force_off_tx_en", 32'(usb_tx_en), 32'd0);

    // Reset in the middle of a byte.
    mon_en = 1'b1;
    pkt.push_back(8'($urandom));
    send_bytes(1'b1);
    repeat (14) @(negedge clk_clk48);
    check("midpkt_tx_en", 32'(usb_tx_en), 32'd1);
    mon_en = 1'b0;
    exp_sym.delete();
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_tx_en", 32'(usb_tx_en), 32'd0);
    check("async_rst_lines", 32'({usb_d_p, usb_d_n}), 32'(SYM_J));
    check("async_rst_pullup", 32'(usb_pullup), 32'd0);
    check("async_rst_clk12", 32'(clk_clk12), 32'd0);
    repeat (3) @(negedge clk_clk48);
    check("rst_hold_tx_en", 32'(usb_tx_en), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk_clk48);
    wb_rd(30'd0, 32'hFFFF_FFFF, 32'd0);
    wb_rd(30'd1, 32'h0000_003C, 32'd0);
    repeat (20) @(negedge clk_clk48);
    check("post_rst_tx_en", 32'(usb_tx_en), 32'd0);
    check("wb_queue_empty", 32'(exp_wb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
